apu_pulse_ctrl: RTL and testbench
=================================

Name: apu_pulse_ctrl

Overview:
- CPU-facing register/timer front end for one APU pulse channel.
- Accepts CPU writes to the four channel registers ($4000–$4003, or $4004–$4007 for pulse 2).
- Runs the 11-bit period timer and the length counter.
- Drives the pulse sequencer: a toggling sequencer clock level, a restart pulse and the duty select. Also drives channel status to the mixer.

Parameters:
- LEN_W, 8, length counter width.
- PER_W, 11, timer period width.

Ports:
- cpu_clk  in  1  CPU clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- apu_cycle  in  1  one-cycle enable, high every 2nd cpu_clk; advances the timer.
- frame_half  in  1  one-cycle half-frame tick from the frame counter; clocks the length counter.
- chan_en  in  1  channel enable bit from $4015.
- wr_en  in  1  CPU register write strobe, one cycle.
- wr_addr  in  2  register select: 0=$4000, 1=$4001, 2=$4002, 3=$4003.
- wr_data  in  8  CPU write data.
- duty  out  2  duty select to the sequencer.
- seq_clk  out  1  toggles once per timer expiry; the sequencer's clock-edge input.
- seq_reset  out  1  one-cycle sequencer restart.
- const_vol  out  1  constant-volume flag.
- volume  out  4  volume/envelope period.
- sweep_reg  out  8  raw $4001 value for the sweep unit.
- timer_period  out  11  current period.
- length_count  out  8  current length counter value.
- length_active  out  1  length_count != 0 (for the $4015 read).
- silenced  out  1  channel output muted.

Behaviour:
- Reset (async, reset_n=0): all registers 0, timer counter 0, seq_clk=0, seq_reset=0, length_count=0. As a result length_active=0 and silenced=1.
- Register writes are captured on the cpu_clk edge when wr_en=1.
  - $4000: duty=d[7:6], halt=d[5], const_vol=d[4], volume=d[3:0].
  - $4001: sweep_reg=d.
  - $4002: timer_period[7:0]=d.
  - $4003: timer_period[10:8]=d[2:0]; length index=d[7:3].
- All register outputs are visible 1 cycle after the write.
- Timer, on apu_cycle=1:
  - If the count is 0: reload with timer_period and toggle seq_clk.
  - Otherwise: decrement.
  - Effective toggle period is (timer_period+1) apu_cycles.
  - Writes to $4002/$4003 do not disturb the running count; the new period takes effect at the next reload.
- seq_reset:
  - Registered; high for exactly the one cycle after the $4003 write cycle.
  - Back-to-back $4003 writes give one pulse per write.
- Length counter:
  - A $4003 write with chan_en=1 loads LENGTH_TABLE[d[7:3]].
  - With chan_en=1, no load, frame_half=1, halt=0 and length!=0: decrement by 1.
  - length_count=0 never wraps.
  - chan_en=0 forces length_count to 0 on the next edge (synchronous clear). Loads are ignored while chan_en=0.
- Simultaneous events:
  - A $4003 load and frame_half in the same cycle: the load wins, with no decrement.
  - A chan_en=0 clear beats both.
  - halt=1 freezes the count but does not block loads.
- silenced = (length_count==0) | (timer_period < 8). Combinational from registered state.
- Reset mid-operation: everything returns to reset values asynchronously. No write is captured while reset_n=0.

Decomposition:
- Package apu_pkg holds:
  - LENGTH_TABLE[32] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - The register address constants REG_CTRL/REG_SWEEP/REG_TLO/REG_THI.
  - PULSE_MIN_PERIOD=8.
- One natural sub-module: apu_length_counter (table lookup, load/decrement/clear/halt priority). This sub-module is reused by the triangle and noise channels.
- The timer and register file stay in the top level.

Test Plan:
- Reset, then write $4002=0x08, $4003=0x00 with chan_en=1 and pulse apu_cycle continuously. Required:
  - seq_clk toggles every 9 apu_cycles.
  - length_count=10.
  - seq_reset is high for 1 cycle after the $4003 write.
- Write $4003=0x08 (index 1), then issue 3 frame_half pulses with halt=0. Required: length 254→251, and length_active=1.
- Write $4000=0x20 (halt) and issue frame_half. Required: length unchanged. Then write $4003 with index 2. Required: length=20.
- Issue the $4003 write (index 0) and frame_half in the same cycle. Required: length=10, not 9. Then drop chan_en. Required: length=0 the next cycle, and a following $4003 write leaves it at 0.
- Set timer_period=7. Required: silenced=1 even with length>0. Set timer_period=8. Required: silenced=0.
- Assert reset_n=0 mid-count with seq_clk=1 and length=20. Required: the outputs clear immediately without a clock edge, and after release the timer restarts from 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants for the APU channel front ends: register map, length table,
// and the pulse-channel minimum period below which the output is muted.
package apu_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SWEEP = 2'd1;
  localparam logic [1:0] REG_TLO   = 2'd2;
  localparam logic [1:0] REG_THI   = 2'd3;

  localparam int PULSE_MIN_PERIOD = 8;

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    return LENGTH_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by pulse, triangle and noise channels.
// Priority: disable clear > table load > halted/ticked decrement.
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_chan_en,
  input  logic             i_load,
  input  logic [4:0]       i_index,
  input  logic             i_tick,
  input  logic             i_halt,
  output logic [LEN_W-1:0] o_count,
  output logic             o_active
);

  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_load_val;

  assign w_load_val = LEN_W'(length_lookup(i_index));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_chan_en) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_val;
    end else if (i_tick && !i_halt && (r_count != '0)) begin
      // Saturates at zero: the guard above stops any wrap.
      r_count <= r_count - LEN_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_active = (r_count != '0);

endmodule

// File: rtl/apu_pulse_ctrl.sv
// Pulse channel front end: CPU register file, period timer driving the
// sequencer clock level, sequencer restart and the length counter.
module apu_pulse_ctrl
  import apu_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int PER_W = 11
) (
  input  logic             cpu_clk,
  input  logic             reset_n,
  input  logic             apu_cycle,
  input  logic             frame_half,
  input  logic             chan_en,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  output logic [1:0]       duty,
  output logic             seq_clk,
  output logic             seq_reset,
  output logic             const_vol,
  output logic [3:0]       volume,
  output logic [7:0]       sweep_reg,
  output logic [PER_W-1:0] timer_period,
  output logic [LEN_W-1:0] length_count,
  output logic             length_active,
  output logic             silenced
);

  logic [1:0]       r_duty;
  logic             r_halt;
  logic             r_const_vol;
  logic [3:0]       r_volume;
  logic [7:0]       r_sweep;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_timer;
  logic             r_seq_clk;
  logic             r_seq_reset;
  logic             w_thi_wr;
  logic [LEN_W-1:0] w_len;
  logic             w_len_active;

  assign w_thi_wr = wr_en && (wr_addr == REG_THI);

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty      <= '0;
      r_halt      <= 1'b0;
      r_const_vol <= 1'b0;
      r_volume    <= '0;
      r_sweep     <= '0;
      r_period    <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        REG_CTRL: begin
          r_duty      <= wr_data[7:6];
          r_halt      <= wr_data[5];
          r_const_vol <= wr_data[4];
          r_volume    <= wr_data[3:0];
        end
        REG_SWEEP: r_sweep         <= wr_data;
        REG_TLO:   r_period[7:0]   <= wr_data;
        default:   r_period[10:8]  <= wr_data[2:0];
      endcase
    end
  end

  // Period writes only land in r_period; the running count picks them up at reload.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_seq_clk <= 1'b0;
    end else if (apu_cycle) begin
      if (r_timer == '0) begin
        r_timer   <= r_period;
        r_seq_clk <= ~r_seq_clk;
      end else begin
        r_timer <= r_timer - PER_W'(1);
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) r_seq_reset <= 1'b0;
    else          r_seq_reset <= w_thi_wr;
  end

  apu_length_counter #(.LEN_W(LEN_W)) u_len (
    .clk      (cpu_clk),
    .rst_n    (reset_n),
    .i_chan_en(chan_en),
    .i_load   (w_thi_wr),
    .i_index  (wr_data[7:3]),
    .i_tick   (frame_half),
    .i_halt   (r_halt),
    .o_count  (w_len),
    .o_active (w_len_active)
  );

  assign duty          = r_duty;
  assign seq_clk       = r_seq_clk;
  assign seq_reset     = r_seq_reset;
  assign const_vol     = r_const_vol;
  assign volume        = r_volume;
  assign sweep_reg     = r_sweep;
  assign timer_period  = r_period;
  assign length_count  = w_len;
  assign length_active = w_len_active;
  assign silenced      = (w_len == '0) | (r_period < PER_W'(PULSE_MIN_PERIOD));

endmodule

// File: tb/tb_apu_pulse_ctrl.sv
// Directed bench for apu_pulse_ctrl: expectations are queued as stimulus is
// driven and popped against DUT outputs sampled 1 time unit after each edge.
module tb_apu_pulse_ctrl;
  import apu_pkg::*;

  logic        cpu_clk;
  logic        reset_n;
  logic        apu_cycle;
  logic        frame_half;
  logic        chan_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  duty;
  logic        seq_clk;
  logic        seq_reset;
  logic        const_vol;
  logic [3:0]  volume;
  logic [7:0]  sweep_reg;
  logic [10:0] timer_period;
  logic [7:0]  length_count;
  logic        length_active;
  logic        silenced;

  logic [15:0] exp_q[$];
  int          n_assert;
  int          n_fail;
  logic        apu_run;
  logic        phase;
  int          napu;

  apu_pulse_ctrl #(.LEN_W(8), .PER_W(11)) dut (
    .cpu_clk      (cpu_clk),
    .reset_n      (reset_n),
    .apu_cycle    (apu_cycle),
    .frame_half   (frame_half),
    .chan_en      (chan_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .duty         (duty),
    .seq_clk      (seq_clk),
    .seq_reset    (seq_reset),
    .const_vol    (const_vol),
    .volume       (volume),
    .sweep_reg    (sweep_reg),
    .timer_period (timer_period),
    .length_count (length_count),
    .length_active(length_active),
    .silenced     (silenced)
  );

  // Clock / reset
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // Scoreboard
  task automatic exp_push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // Drivers: one clock per cyc(); apu_cycle runs every 2nd clock when enabled.
  task automatic cyc();
    apu_cycle = apu_run ? phase : 1'b0;
    phase     = ~phase;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_half = 1'b1;
    cyc();
    frame_half = 1'b0;
    cyc();
  endtask

  // Counts apu_cycle edges until seq_clk changes; -1 on timeout.
  task automatic wait_toggle(output int n);
    logic prev;
    prev = seq_clk;
    n    = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (apu_cycle) n++;
      if (seq_clk !== prev) return;
    end
    n = -1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    apu_cycle  = 1'b0;
    frame_half = 1'b0;
    chan_en    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 2'd0;
    wr_data    = 8'd0;
    apu_run    = 1'b0;
    phase      = 1'b0;

    // Reset state
    #12;
    exp_push(16'h0); check("rst_period", 16'(timer_period));
    exp_push(16'h0); check("rst_length", 16'(length_count));
    exp_push(16'h0); check("rst_active", 16'(length_active));
    exp_push(16'h1); check("rst_silenced", 16'(silenced));
    exp_push(16'h0); check("rst_seq_clk", 16'(seq_clk));
    exp_push(16'h0); check("rst_seq_reset", 16'(seq_reset));
    exp_push(16'h0); check("rst_duty", 16'(duty));
    @(posedge cpu_clk);
    #1;
    reset_n = 1'b1;
    chan_en = 1'b1;

    // Period 8, length index 0
    write_reg(REG_TLO, 8'h08);
    exp_push(16'h8); check("period_lo", 16'(timer_period));
    write_reg(REG_THI, 8'h00);
    exp_push(16'h1); check("seq_reset_hi", 16'(seq_reset));
    exp_push(16'd10); check("len_idx0", 16'(length_count));
    exp_push(16'h0); check("not_silenced", 16'(silenced));
    cyc();
    exp_push(16'h0); check("seq_reset_lo", 16'(seq_reset));

    // Timer toggles: first on the idle count of 0, then every period+1 apu_cycles
    apu_run = 1'b1;
    wait_toggle(napu);
    exp_push(16'd1); check("first_toggle", 16'(napu));
    exp_push(16'h1); check("seq_clk_hi", 16'(seq_clk));
    wait_toggle(napu);
    exp_push(16'd9); check("toggle_period_a", 16'(napu));
    exp_push(16'h0); check("seq_clk_lo", 16'(seq_clk));
    wait_toggle(napu);
    exp_push(16'd9); check("toggle_period_b", 16'(napu));
    exp_push(16'd10); check("len_hold", 16'(length_count));

    // Length decrement
    write_reg(REG_THI, 8'h08);
    exp_push(16'd254); check("len_idx1", 16'(length_count));
    for (int i = 0; i < 3; i++) frame_pulse();
    exp_push(16'd251); check("len_dec3", 16'(length_count));
    exp_push(16'h1); check("len_active", 16'(length_active));

    // Control register fields and halt
    write_reg(REG_CTRL, 8'hBA);
    exp_push(16'h2); check("duty", 16'(duty));
    exp_push(16'h1); check("const_vol", 16'(const_vol));
    exp_push(16'hA); check("volume", 16'(volume));
    frame_pulse();
    exp_push(16'd251); check("len_halted", 16'(length_count));
    write_reg(REG_SWEEP, 8'h5C);
    exp_push(16'h5C); check("sweep_reg", 16'(sweep_reg));
    write_reg(REG_THI, 8'h10);
    exp_push(16'd20); check("len_load_halted", 16'(length_count));

    // Load beats frame_half in the same cycle
    write_reg(REG_CTRL, 8'h00);
    frame_half = 1'b1;
    write_reg(REG_THI, 8'h00);
    frame_half = 1'b0;
    exp_push(16'd10); check("load_beats_tick", 16'(length_count));
    frame_pulse();
    exp_push(16'd9); check("len_dec_unhalted", 16'(length_count));

    // chan_en=0 clears and blocks loads
    chan_en = 1'b0;
    cyc();
    exp_push(16'h0); check("len_disabled", 16'(length_count));
    exp_push(16'h0); check("active_disabled", 16'(length_active));
    exp_push(16'h1); check("silenced_len0", 16'(silenced));
    write_reg(REG_THI, 8'h08);
    exp_push(16'h1); check("b2b_seq_reset_1", 16'(seq_reset));
    exp_push(16'h0); check("len_load_blocked", 16'(length_count));
    write_reg(REG_THI, 8'h08);
    exp_push(16'h1); check("b2b_seq_reset_2", 16'(seq_reset));
    cyc();
    exp_push(16'h0); check("b2b_seq_reset_end", 16'(seq_reset));

    // Period high bits and the silencing threshold
    chan_en = 1'b1;
    write_reg(REG_THI, 8'h15);
    exp_push(16'd20); check("len_idx2", 16'(length_count));
    exp_push(16'h508); check("period_hi", 16'(timer_period));
    write_reg(REG_THI, 8'h10);
    exp_push(16'h008); check("period_hi_clr", 16'(timer_period));
    write_reg(REG_TLO, 8'h07);
    exp_push(16'h1); check("silenced_p7", 16'(silenced));
    exp_push(16'h1); check("active_p7", 16'(length_active));
    write_reg(REG_TLO, 8'h08);
    exp_push(16'h0); check("silenced_p8", 16'(silenced));

    // Asynchronous reset while seq_clk=1 and length=20
    for (int i = 0; i < 40; i++) begin
      if (seq_clk === 1'b1) break;
      cyc();
    end
    exp_push(16'h1); check("pre_rst_seq_clk", 16'(seq_clk));
    exp_push(16'd20); check("pre_rst_len", 16'(length_count));
    #2;
    reset_n = 1'b0;
    #1;
    exp_push(16'h0); check("arst_seq_clk", 16'(seq_clk));
    exp_push(16'h0); check("arst_len", 16'(length_count));
    exp_push(16'h0); check("arst_period", 16'(timer_period));
    exp_push(16'h1); check("arst_silenced", 16'(silenced));
    exp_push(16'h0); check("arst_sweep", 16'(sweep_reg));
    apu_run = 1'b0;
    write_reg(REG_TLO, 8'h20);
    exp_push(16'h0); check("no_write_in_rst", 16'(timer_period));
    reset_n = 1'b1;
    write_reg(REG_TLO, 8'h08);
    exp_push(16'h0); check("post_rst_seq_clk", 16'(seq_clk));
    apu_run = 1'b1;
    wait_toggle(napu);
    exp_push(16'd1); check("restart_from_0", 16'(napu));
    wait_toggle(napu);
    exp_push(16'd9); check("restart_period", 16'(napu));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
